// File: rtl/chacha_stream_ctrl_pkg.sv
// Shared constants for the chacha stream controller and the chacha register top:
// bus register map, status bit positions, control command values and the
// controller state encoding.
package chacha_stream_ctrl_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'h08;
  localparam logic [7:0] ADDR_STATUS    = 8'h09;
  localparam logic [7:0] ADDR_ROUNDS    = 8'h0b;
  localparam logic [7:0] ADDR_KEY0      = 8'h10;
  localparam logic [7:0] ADDR_IV0       = 8'h20;
  localparam logic [7:0] ADDR_DATA_IN0  = 8'h40;
  localparam logic [7:0] ADDR_DATA_OUT0 = 8'h80;

  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_VALID_BIT = 1;

  localparam logic [31:0] CTRL_INIT = 32'h0000_0001;
  localparam logic [31:0] CTRL_NEXT = 32'h0000_0002;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LD_KEY    = 4'd1;
  localparam logic [3:0] S_LD_IV     = 4'd2;
  localparam logic [3:0] S_LD_ROUNDS = 4'd3;
  localparam logic [3:0] S_LD_DATA   = 4'd4;
  localparam logic [3:0] S_CTRL      = 4'd5;
  localparam logic [3:0] S_WAIT_BUSY = 4'd6;
  localparam logic [3:0] S_POLL      = 4'd7;
  localparam logic [3:0] S_DRAIN     = 4'd8;

endpackage

// File: rtl/chacha_stream_ctrl_if.sv
// Register bus between the stream controller (master) and the chacha top (slave).
//  cs, we      chip select / write enable
//  addr        8-bit register address
//  write_data  32-bit write data
//  read_data   32-bit read data, combinational from addr while cs&!we
interface chacha_stream_ctrl_if;
  logic        cs;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output cs, output we, output addr, output write_data, input read_data);
  modport slave  (input cs, input we, input addr, input write_data, output read_data);
endinterface

// File: rtl/chacha_stream_ctrl.sv
// Bus-master sequencer for the chacha register top. Loads key/IV/rounds, writes
// data_in blocks from an input word stream, issues init/next, polls status and
// streams data_out back out.
//  clk, reset               clock, synchronous active-high reset
//  i_cfg_start/key/nonce/rounds  per-message configuration, captured in IDLE
//  i_in_valid/o_in_ready/i_in_data/i_in_last      input word stream
//  o_out_valid/i_out_ready/o_out_data/o_out_last  result word stream
//  o_busy                   high outside IDLE
//  o_error                  sticky poll timeout
//  bus                      register bus master
//
//  state      | meaning
//  IDLE       | waiting for cfg_start
//  LD_KEY     | 8 key word writes
//  LD_IV      | 3 nonce word writes
//  LD_ROUNDS  | rounds register write
//  LD_DATA    | accept up to 16 input words, one data_in write each
//  CTRL       | init (first block) or next command write
//  WAIT_BUSY  | wait for status.ready to drop
//  POLL       | wait for status.ready & status.valid
//  DRAIN      | read data_out words onto the output stream
module chacha_stream_ctrl
  import chacha_stream_ctrl_pkg::*;
#(
  parameter int BUSY_WAIT_MAX = 8,
  parameter int TIMEOUT_MAX   = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_cfg_start,
  input  logic [255:0] i_cfg_key,
  input  logic [95:0]  i_cfg_nonce,
  input  logic [4:0]   i_cfg_rounds,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [31:0]  i_in_data,
  input  logic         i_in_last,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [31:0]  o_out_data,
  output logic         o_out_last,
  output logic         o_busy,
  output logic         o_error,
  chacha_stream_ctrl_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_MAX + 1);
  localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_WAIT_MAX - 1);
  localparam logic [TW-1:0] POLL_LAST = TW'(TIMEOUT_MAX - 1);

  logic [3:0]    r_state;
  logic [255:0]  r_key;
  logic [95:0]   r_nonce;
  logic [4:0]    r_rounds;
  logic [3:0]    r_idx;
  logic [3:0]    r_last_idx;
  logic          r_last_blk;
  logic          r_first_blk;
  logic [TW-1:0] r_tmo;
  logic          r_error;

  logic [31:0] w_key_words [8];
  logic [31:0] w_iv_word;
  logic        w_rdy;
  logic        w_vld;

  always_comb begin
    for (int i = 0; i < 8; i++) w_key_words[i] = r_key[255-32*i -: 32];
    case (r_idx[1:0])
      2'd0:    w_iv_word = r_nonce[95:64];
      2'd1:    w_iv_word = r_nonce[63:32];
      default: w_iv_word = r_nonce[31:0];
    endcase
  end

  assign w_rdy   = bus.read_data[STATUS_READY_BIT];
  assign w_vld   = bus.read_data[STATUS_VALID_BIT];
  assign o_busy  = (r_state != S_IDLE);
  assign o_error = r_error;

  always_comb begin
    bus.cs         = 1'b0;
    bus.we         = 1'b0;
    bus.addr       = 8'h00;
    bus.write_data = 32'h0;
    o_in_ready     = 1'b0;
    o_out_valid    = 1'b0;
    o_out_data     = 32'h0;
    o_out_last     = 1'b0;
    case (r_state)
      S_LD_KEY: begin
        bus.cs = 1'b1; bus.we = 1'b1;
        bus.addr = ADDR_KEY0 + {4'h0, r_idx};
        bus.write_data = w_key_words[r_idx[2:0]];
      end
      S_LD_IV: begin
        bus.cs = 1'b1; bus.we = 1'b1;
        bus.addr = ADDR_IV0 + {4'h0, r_idx};
        bus.write_data = w_iv_word;
      end
      S_LD_ROUNDS: begin
        bus.cs = 1'b1; bus.we = 1'b1;
        bus.addr = ADDR_ROUNDS;
        bus.write_data = {27'h0, r_rounds};
      end
      S_LD_DATA: begin
        // The write rides on the handshake so each accepted word costs one cycle.
        o_in_ready = 1'b1;
        bus.cs = i_in_valid; bus.we = i_in_valid;
        bus.addr = ADDR_DATA_IN0 + {4'h0, r_idx};
        bus.write_data = i_in_data;
      end
      S_CTRL: begin
        bus.cs = 1'b1; bus.we = 1'b1;
        bus.addr = ADDR_CTRL;
        bus.write_data = r_first_blk ? CTRL_INIT : CTRL_NEXT;
      end
      S_WAIT_BUSY, S_POLL: begin
        bus.cs = 1'b1;
        bus.addr = ADDR_STATUS;
      end
      S_DRAIN: begin
        bus.cs = 1'b1;
        bus.addr = ADDR_DATA_OUT0 + {4'h0, r_idx};
        o_out_valid = 1'b1;
        o_out_data = bus.read_data;
        o_out_last = r_last_blk && (r_idx == r_last_idx);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_key       <= '0;
      r_nonce     <= '0;
      r_rounds    <= '0;
      r_idx       <= '0;
      r_last_idx  <= '0;
      r_last_blk  <= 1'b0;
      r_first_blk <= 1'b0;
      r_tmo       <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_cfg_start) begin
          r_key       <= i_cfg_key;
          r_nonce     <= i_cfg_nonce;
          r_rounds    <= i_cfg_rounds;
          r_error     <= 1'b0;
          r_first_blk <= 1'b1;
          r_idx       <= '0;
          r_state     <= S_LD_KEY;
        end
        S_LD_KEY: if (r_idx == 4'd7) begin
          r_idx <= '0; r_state <= S_LD_IV;
        end else r_idx <= r_idx + 4'd1;
        S_LD_IV: if (r_idx == 4'd2) begin
          r_idx <= '0; r_state <= S_LD_ROUNDS;
        end else r_idx <= r_idx + 4'd1;
        S_LD_ROUNDS: begin
          r_idx <= '0; r_state <= S_LD_DATA;
        end
        S_LD_DATA: if (i_in_valid) begin
          if (r_idx == 4'd15 || i_in_last) begin
            r_last_idx <= r_idx;
            r_last_blk <= i_in_last;
            r_idx      <= '0;
            r_state    <= S_CTRL;
          end else r_idx <= r_idx + 4'd1;
        end
        S_CTRL: begin
          r_first_blk <= 1'b0;
          r_tmo       <= '0;
          r_state     <= S_WAIT_BUSY;
        end
        // Proceed to polling even if ready never visibly drops.
        S_WAIT_BUSY: if (!w_rdy || r_tmo == BUSY_LAST) begin
          r_tmo <= '0; r_state <= S_POLL;
        end else r_tmo <= r_tmo + TW'(1);
        S_POLL: if (w_rdy && w_vld) begin
          r_idx <= '0; r_state <= S_DRAIN;
        end else if (r_tmo == POLL_LAST) begin
          r_error <= 1'b1; r_state <= S_IDLE;
        end else if (r_tmo != '1) r_tmo <= r_tmo + TW'(1);
        S_DRAIN: if (i_out_ready) begin
          if (r_idx == r_last_idx) begin
            r_idx   <= '0;
            r_state <= r_last_blk ? S_IDLE : S_LD_DATA;
          end else r_idx <= r_idx + 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
module tb_chacha_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         i_cfg_start;
  logic [255:0] i_cfg_key;
  logic [95:0]  i_cfg_nonce;
  logic [4:0]   i_cfg_rounds;
  logic         i_in_valid;
  logic         o_in_ready;
  logic [31:0]  i_in_data;
  logic         i_in_last;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [31:0]  o_out_data;
  logic         o_out_last;
  logic         o_busy;
  logic         o_error;

  chacha_stream_ctrl_if bus();

  chacha_stream_ctrl #(.BUSY_WAIT_MAX(8), .TIMEOUT_MAX(1023)) dut (
    .clk(clk), .reset(reset),
    .i_cfg_start(i_cfg_start), .i_cfg_key(i_cfg_key), .i_cfg_nonce(i_cfg_nonce),
    .i_cfg_rounds(i_cfg_rounds),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .i_in_last(i_in_last),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_last(o_out_last),
    .o_busy(o_busy), .o_error(o_error),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Simplified chacha top model: data_out[k] = data_in[k] ^ ks(block, k).
  logic        m_ready, m_valid;
  logic [31:0] m_din  [16];
  logic [31:0] m_dout [16];
  logic [7:0]  m_blk;
  int          m_cnt;
  int          m_delay = 4;
  bit          m_stuck = 1'b0;
  logic [39:0] wlog [$];
  int          n_status_rd = 0;

  function automatic logic [31:0] ks(input logic [7:0] b, input int k);
    return 32'h6A09_E600 ^ {16'h0, b, 8'(k)};
  endfunction

  function automatic logic [31:0] kw(input logic [255:0] key, input int i);
    return key[255-32*i -: 32];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_cnt <= 0; m_blk <= 8'd0;
    end else begin
      if (bus.cs && !bus.we && bus.addr == 8'h09) n_status_rd <= n_status_rd + 1;
      if (bus.cs && bus.we) begin
        wlog.push_back({bus.addr, bus.write_data});
        if (bus.addr[7:4] == 4'h4) m_din[bus.addr[3:0]] <= bus.write_data;
        if (bus.addr == 8'h08) begin
          m_ready <= 1'b0; m_valid <= 1'b0; m_cnt <= m_delay;
          m_blk <= (bus.write_data == 32'h1) ? 8'd0 : m_blk + 8'd1;
        end
      end else if (!m_ready && !m_stuck) begin
        if (m_cnt == 0) begin
          m_ready <= 1'b1; m_valid <= 1'b1;
          for (int k = 0; k < 16; k++) m_dout[k] <= m_din[k] ^ ks(m_blk, k);
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  always_comb begin
    bus.read_data = 32'h0;
    if (bus.addr == 8'h09) bus.read_data = {30'h0, m_valid, m_ready};
    else if (bus.addr[7:4] == 4'h8) bus.read_data = m_dout[bus.addr[3:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_msg(input logic [255:0] key, input logic [95:0] nonce, input logic [4:0] rounds);
    i_cfg_key = key; i_cfg_nonce = nonce; i_cfg_rounds = rounds; i_cfg_start = 1'b1;
    @(negedge clk);
    i_cfg_start = 1'b0;
  endtask

  task automatic send(input int n, input logic [31:0] base, input logic [31:0] step);
    int g;
    for (int i = 0; i < n; i++) begin
      i_in_valid = 1'b1; i_in_data = base + 32'(i) * step; i_in_last = (i == n - 1);
      g = 0;
      while (!o_in_ready && g < 20000) begin @(negedge clk); g++; end
      if (g >= 20000) begin chk("send_timeout", o_in_ready, 1); break; end
      @(negedge clk);
    end
    i_in_valid = 1'b0; i_in_last = 1'b0;
  endtask

  task automatic collect(input int n, input logic [31:0] base, input logic [31:0] step, input bit stall);
    int j = 0, cyc = 0, guard = 0;
    bit held = 1'b0;
    logic [7:0] h_addr;
    logic [31:0] h_data, e;
    while (j < n && guard < 20000) begin
      @(negedge clk); guard++;
      i_out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      cyc++;
      if (o_out_valid) begin
        if (held) begin
          chk("stall_addr", bus.addr, h_addr);
          chk("stall_data", o_out_data, h_data);
        end
        if (i_out_ready) begin
          e = (base + 32'(j) * step) ^ ks(8'(j / 16), j % 16);
          chk("out_data", o_out_data, e);
          chk("out_last", o_out_last, (j == n - 1));
          j++; held = 1'b0;
        end else begin
          held = 1'b1; h_addr = bus.addr; h_data = o_out_data;
        end
      end
    end
    chk("out_count", j, n);
  endtask

  task automatic run_body(input int n, input logic [31:0] base, input logic [31:0] step, input bit stall);
    fork
      send(n, base, step);
      collect(n, base, step, stall);
    join
    @(negedge clk);
    i_out_ready = 1'b0;
    chk("idle_after_msg", o_busy, 0);
    chk("cs_idle", bus.cs, 0);
  endtask

  task automatic check_cfg_trace(input int lb, input logic [255:0] key, input logic [95:0] nonce,
                                 input logic [4:0] rounds);
    for (int i = 0; i < 8; i++) chk("key_wr", wlog[lb+i], {8'h10 + 8'(i), kw(key, i)});
    for (int i = 0; i < 3; i++) chk("iv_wr", wlog[lb+8+i], {8'h20 + 8'(i), nonce[95-32*i -: 32]});
    chk("rounds_wr", wlog[lb+11], {8'h0b, 27'h0, rounds});
  endtask

  task automatic check_ctrl_writes(input int lb, input int nexp, input logic [31:0] first_val);
    int nc = 0;
    for (int i = lb; i < wlog.size(); i++) begin
      if (wlog[i][39:32] == 8'h08) begin
        chk("ctrl_val", wlog[i][31:0], (nc == 0) ? first_val : 32'h2);
        nc++;
      end
    end
    chk("ctrl_count", nc, nexp);
  endtask

  initial begin
    int lb, sb, g;
    logic [255:0] ka, kb;
    reset = 1'b1; i_cfg_start = 1'b0; i_cfg_key = '0; i_cfg_nonce = '0; i_cfg_rounds = '0;
    i_in_valid = 1'b0; i_in_data = '0; i_in_last = 1'b0; i_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_error", o_error, 0);
    chk("rst_cs", bus.cs, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wdata", bus.write_data, 0);
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_last", o_out_last, 0);

    // 1: zero key/nonce, 16 zero words, full trace
    lb = wlog.size();
    start_msg('0, '0, 5'd20);
    chk("busy_after_start", o_busy, 1);
    run_body(16, 32'h0, 32'h0, 1'b0);
    chk("t1_nwrites", wlog.size() - lb, 29);
    check_cfg_trace(lb, '0, '0, 5'd20);
    for (int k = 0; k < 16; k++) chk("data_wr", wlog[lb+12+k], {8'h40 + 8'(k), 32'h0});
    chk("ctrl_init", wlog[lb+28], {8'h08, 32'h1});

    // 2: 40-word message over three blocks
    lb = wlog.size();
    start_msg({8{32'h0102_0304}}, 96'h1, 5'd12);
    run_body(40, 32'h1000_0000, 32'h0001_0003, 1'b0);
    check_ctrl_writes(lb, 3, 32'h1);

    // 3: downstream stalls during DRAIN
    start_msg({8{32'hCAFE_F00D}}, 96'h2, 5'd8);
    run_body(20, 32'hABCD_0000, 32'h0000_0101, 1'b1);

    // 4: ready never returns -> poll timeout
    m_stuck = 1'b1;
    start_msg('0, '0, 5'd20);
    sb = n_status_rd;
    send(16, 32'h5, 32'h1);
    g = 0;
    while (!o_error && g < 3000) begin @(negedge clk); g++; end
    chk("t4_error", o_error, 1);
    chk("t4_busy", o_busy, 0);
    chk("t4_in_ready", o_in_ready, 0);
    chk("t4_out_valid", o_out_valid, 0);
    chk("t4_status_reads", n_status_rd - sb, 1024);
    repeat (5) @(negedge clk);
    chk("t4_error_sticky", o_error, 1);
    m_stuck = 1'b0;

    // 5: reset during POLL, then a clean message
    m_delay = 30;
    start_msg('0, '0, 5'd20);
    chk("t5_error_cleared", o_error, 0);
    send(16, 32'h77, 32'h3);
    repeat (6) @(negedge clk);
    chk("t5_in_poll", {bus.cs, bus.we, bus.addr}, {1'b1, 1'b0, 8'h09});
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_cs", bus.cs, 0);
    chk("t5_rst_out_valid", o_out_valid, 0);
    reset = 1'b0;
    m_delay = 4;
    @(negedge clk);
    lb = wlog.size();
    start_msg({8{32'h1357_9BDF}}, 96'h3, 5'd20);
    run_body(16, 32'h2222_0000, 32'h11, 1'b0);
    check_ctrl_writes(lb, 1, 32'h1);

    // 6: cfg_start while busy is ignored
    ka = {32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF,
          32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};
    kb = ~ka;
    lb = wlog.size();
    start_msg(ka, 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF, 5'd12);
    i_cfg_key = kb; i_cfg_nonce = 96'h1; i_cfg_rounds = 5'd8; i_cfg_start = 1'b1;
    @(negedge clk);
    i_cfg_start = 1'b0;
    run_body(16, 32'h9000_0000, 32'h7, 1'b0);
    check_cfg_trace(lb, ka, 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF, 5'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
